// File: rtl/pu_ia_ic_fill.sv
// Instruction-cache refill/invalidate controller: single-word miss refill over the system bus plus full-cache invalidate sweeps.
// Optional build macro PU_IC_FILL_INV_ON_RESET_EN: start with an invalidate sweep pending out of reset.
module pu_ia_ic_fill #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 22,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_on,
    input  logic               i_miss_req,
    input  logic [ADDR_W-1:0]  i_miss_addr,
    output logic               o_miss_ack,
    output logic [DATA_W-1:0]  o_miss_data,
    output logic               o_miss_err,
    input  logic               i_inv_all,
    output logic               o_inv_busy,
    output logic               o_bus_req,
    output logic [ADDR_W-1:0]  o_bus_addr,
    input  logic               i_bus_rdy,
    input  logic [DATA_W-1:0]  i_bus_rd_data,
    input  logic               i_bus_err,
    output logic [INDEX_W-1:0] o_rw_index,
    output logic               o_wr_en,
    output logic [TAG_W-1:0]   o_wr_ptag,
    output logic               o_wr_valid,
    output logic [DATA_W-1:0]  o_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BUS  = 3'd1,
        S_FILL = 3'd2,
        S_RESP = 3'd3,
        S_INV  = 3'd4
    } state_t;

`ifdef PU_IC_FILL_INV_ON_RESET_EN
    localparam logic C_PEND_RST = 1'b1;
`else
    localparam logic C_PEND_RST = 1'b0;
`endif
    localparam logic [INDEX_W-1:0] C_LAST      = {INDEX_W{1'b1}};
    localparam logic [INDEX_W-1:0] C_ONE       = {{(INDEX_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]  C_WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t             r_state, w_next;
    logic               r_pend, w_pend_next;
    logic [INDEX_W-1:0] r_cnt, w_cnt_next;
    logic [TAG_W-1:0]   r_tag;
    logic [INDEX_W-1:0] r_index;

    logic               w_miss_ack, w_miss_err, w_inv_busy, w_bus_req;
    logic               w_wr_en, w_wr_valid;
    logic [DATA_W-1:0]  w_miss_data, w_wr_data;
    logic [ADDR_W-1:0]  w_bus_addr;
    logic [INDEX_W-1:0] w_rw_index;
    logic [TAG_W-1:0]   w_wr_ptag;

    // State register, pending-invalidate flag, sweep counter and latched miss line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pend  <= C_PEND_RST;
            r_cnt   <= {INDEX_W{1'b0}};
            r_tag   <= {TAG_W{1'b0}};
            r_index <= {INDEX_W{1'b0}};
        end else begin
            r_state <= w_next;
            r_pend  <= w_pend_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && w_next == S_BUS) begin
                r_tag   <= i_miss_addr[ADDR_W-1:INDEX_W+2];
                r_index <= i_miss_addr[INDEX_W+1:2];
            end
        end
    end

    // Next-state logic; a sweep request beats a miss in IDLE and is deferred while a miss is in flight.
    always_comb begin
        w_next      = r_state;
        w_pend_next = r_pend;
        w_cnt_next  = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_inv_all || r_pend) begin
                    w_next      = S_INV;
                    w_pend_next = 1'b0;
                    w_cnt_next  = {INDEX_W{1'b0}};
                end else if (i_miss_req) begin
                    w_next = S_BUS;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_BUS: begin
                if (i_inv_all) begin
                    w_pend_next = 1'b1;
                end else begin
                    w_pend_next = r_pend;
                end
                if (i_bus_rdy) begin
                    w_next = (!i_bus_err && i_on) ? S_FILL : S_RESP;
                end else begin
                    w_next = S_BUS;
                end
            end
            S_FILL, S_RESP: begin
                if (i_inv_all) begin
                    w_pend_next = 1'b1;
                end else begin
                    w_pend_next = r_pend;
                end
                w_next = S_IDLE;
            end
            S_INV: begin
                w_cnt_next = r_cnt + C_ONE;
                if (r_cnt == C_LAST) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_INV;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle; array-side fields hold when no write is issued.
    always_comb begin
        w_bus_req   = (w_next == S_BUS);
        w_bus_addr  = o_bus_addr;
        w_miss_ack  = (w_next == S_FILL) || (w_next == S_RESP);
        w_miss_data = o_miss_data;
        w_miss_err  = (w_next == S_RESP) && i_bus_err;
        w_inv_busy  = (w_next == S_INV) || w_pend_next;
        w_wr_en     = (w_next == S_FILL) || (w_next == S_INV);
        w_wr_valid  = (w_next == S_FILL);
        w_rw_index  = o_rw_index;
        w_wr_ptag   = o_wr_ptag;
        w_wr_data   = o_wr_data;
        if (r_state == S_IDLE && w_next == S_BUS) begin
            w_bus_addr = i_miss_addr & C_WORD_MASK;
        end else begin
            w_bus_addr = o_bus_addr;
        end
        if (w_miss_ack) begin
            w_miss_data = i_bus_rd_data;
        end else begin
            w_miss_data = o_miss_data;
        end
        case (w_next)
            S_FILL: begin
                w_rw_index = r_index;
                w_wr_ptag  = r_tag;
                w_wr_data  = i_bus_rd_data;
            end
            S_INV: begin
                w_rw_index = w_cnt_next;
                w_wr_ptag  = {TAG_W{1'b0}};
                w_wr_data  = {DATA_W{1'b0}};
            end
            default: begin
                w_rw_index = o_rw_index;
                w_wr_ptag  = o_wr_ptag;
                w_wr_data  = o_wr_data;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bus_req   <= 1'b0;
            o_bus_addr  <= {ADDR_W{1'b0}};
            o_miss_ack  <= 1'b0;
            o_miss_data <= {DATA_W{1'b0}};
            o_miss_err  <= 1'b0;
            o_inv_busy  <= C_PEND_RST;
            o_wr_en     <= 1'b0;
            o_wr_valid  <= 1'b0;
            o_rw_index  <= {INDEX_W{1'b0}};
            o_wr_ptag   <= {TAG_W{1'b0}};
            o_wr_data   <= {DATA_W{1'b0}};
        end else begin
            o_bus_req   <= w_bus_req;
            o_bus_addr  <= w_bus_addr;
            o_miss_ack  <= w_miss_ack;
            o_miss_data <= w_miss_data;
            o_miss_err  <= w_miss_err;
            o_inv_busy  <= w_inv_busy;
            o_wr_en     <= w_wr_en;
            o_wr_valid  <= w_wr_valid;
            o_rw_index  <= w_rw_index;
            o_wr_ptag   <= w_wr_ptag;
            o_wr_data   <= w_wr_data;
        end
    end

endmodule
